// File: rtl/alu_8bit_unit.sv
// Registered 8-bit ALU: 16 opcodes, 8-bit result plus 8-bit auxiliary carry word.
// Define ALU_DIV_EN to build the combinational divider for opcode 0x3.
module alu_8bit_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] opcode,
  output logic [7:0] carry,
  output logic [7:0] result
);

  logic [7:0]  result_d, carry_d, result_q, carry_q;
  logic [8:0]  sum;
  logic [7:0]  diff;
  logic [15:0] prod;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = A - B;
  assign prod = {8'h00, A} * {8'h00, B};

  always_comb begin
    result_d = 8'h00;
    carry_d  = 8'h00;
    casez (opcode)
      4'h0: begin result_d = sum[7:0]; carry_d = {7'b0, sum[8]}; end
      4'h1: begin result_d = diff;     carry_d = {7'b0, A < B};  end
      4'h2: begin result_d = prod[7:0]; carry_d = prod[15:8];    end
`ifdef ALU_DIV_EN
      4'h3: begin
        // Divide by zero saturates both words rather than trapping.
        if (B == 8'h00) begin
          result_d = 8'hFF;
          carry_d  = 8'hFF;
        end else begin
          result_d = A / B;
          carry_d  = A % B;
        end
      end
`else
      4'h3: begin result_d = 8'h00; carry_d = 8'h00; end
`endif
      4'h4: begin result_d = {A[6:0], 1'b0}; carry_d = {7'b0, A[7]}; end
      4'h5: begin result_d = {1'b0, A[7:1]}; carry_d = {7'b0, A[0]}; end
      4'h6: result_d = {A[6:0], A[7]};
      4'h7: result_d = {A[0], A[7:1]};
      4'h8: result_d = A & B;
      4'h9: result_d = A | B;
      4'hA: result_d = A ^ B;
      4'hB: result_d = ~(A | B);
      4'hC: result_d = ~(A & B);
      4'hD: result_d = ~(A ^ B);
      4'hE: begin result_d = {7'b0, A > B}; carry_d = {7'b0, A < B}; end
      4'hF: result_d = {7'b0, A == B};
      default: begin result_d = 8'h00; carry_d = 8'h00; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 8'h00;
      carry_q  <= 8'h00;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_alu_8bit_unit.sv
// Self-checking bench for alu_8bit_unit: directed plan vectors plus random ops vs an arithmetic model.
module tb_alu_8bit_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] A = 8'h00, B = 8'h00;
  logic [3:0] opcode = 4'h0;
  logic [7:0] carry, result;
  int tests = 0;
  int fails = 0;

  alu_8bit_unit dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .opcode(opcode),
                     .carry(carry), .result(result));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  task automatic model(input int a, input int b, input int op, output int r, output int c);
    int s;
    r = 0; c = 0;
    case (op)
      0: begin s = a + b; r = s % 256; c = s / 256; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: begin s = a * b; r = s % 256; c = s / 256; end
      3: begin
`ifdef ALU_DIV_EN
        if (b == 0) begin r = 255; c = 255; end
        else begin r = a / b; c = a % b; end
`endif
      end
      4: begin r = (a * 2) % 256; c = a / 128; end
      5: begin r = a / 2; c = a % 2; end
      6: r = (a * 2) % 256 + a / 128;
      7: r = a / 2 + (a % 2) * 128;
      8: r = a & b;
      9: r = a | b;
      10: r = a ^ b;
      11: r = 255 - (a | b);
      12: r = 255 - (a & b);
      13: r = 255 - (a ^ b);
      14: begin r = (a > b) ? 1 : 0; c = (a < b) ? 1 : 0; end
      default: r = (a == b) ? 1 : 0;
    endcase
  endtask

  // Drive on the falling edge, check just after the next rising edge.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] op, input logic [7:0] er, input logic [7:0] ec);
    @(negedge clk);
    A = a; B = b; opcode = op;
    @(posedge clk); #1;
    check({tag, ".result"}, result, er);
    check({tag, ".carry"}, carry, ec);
  endtask

  task automatic step_model(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] op);
    int r, c;
    model(int'(a), int'(b), int'(op), r, c);
    step(tag, a, b, op, r[7:0], c[7:0]);
  endtask

  initial begin
    // Reset asserted off-edge must clear immediately
    rst_n = 1'b1;
    A = 8'hFF; B = 8'hFF; opcode = 4'h2;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async.result", result, 8'h00);
    check("rst_async.carry", carry, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold.result", result, 8'h00);
    check("rst_hold.carry", carry, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    step("add", 8'hAE, 8'hE6, 4'h0, 8'h94, 8'h01);
    step("sub", 8'hAE, 8'hE6, 4'h1, 8'hC8, 8'h01);
    step("mul", 8'hAE, 8'hE6, 4'h2, 8'h54, 8'h9C);
`ifdef ALU_DIV_EN
    step("div", 8'hAE, 8'hE6, 4'h3, 8'h00, 8'hAE);
    step("div0", 8'hAE, 8'h00, 4'h3, 8'hFF, 8'hFF);
    step("div7", 8'hAE, 8'h07, 4'h3, 8'h18, 8'h06);
`else
    step("div_off", 8'hAE, 8'h07, 4'h3, 8'h00, 8'h00);
    step("div0_off", 8'hAE, 8'h00, 4'h3, 8'h00, 8'h00);
`endif
    step("shl", 8'hAE, 8'hE6, 4'h4, 8'h5C, 8'h01);
    step("shr", 8'hAE, 8'hE6, 4'h5, 8'h57, 8'h00);
    step("rol", 8'hAE, 8'hE6, 4'h6, 8'h5D, 8'h00);
    step("ror", 8'hAE, 8'hE6, 4'h7, 8'h57, 8'h00);
    step("and", 8'hAE, 8'hE6, 4'h8, 8'hA6, 8'h00);
    step("or", 8'hAE, 8'hE6, 4'h9, 8'hEE, 8'h00);
    step("xor", 8'hAE, 8'hE6, 4'hA, 8'h48, 8'h00);
    step("nor", 8'hAE, 8'hE6, 4'hB, 8'h11, 8'h00);
    step("nand", 8'hAE, 8'hE6, 4'hC, 8'h59, 8'h00);
    step("xnor", 8'hAE, 8'hE6, 4'hD, 8'hB7, 8'h00);
    step("cmp_lt", 8'hAE, 8'hE6, 4'hE, 8'h00, 8'h01);
    step("eq_ne", 8'hAE, 8'hE6, 4'hF, 8'h00, 8'h00);
    step("cmp_eq", 8'h5A, 8'h5A, 4'hE, 8'h00, 8'h00);
    step("eq_eq", 8'h5A, 8'h5A, 4'hF, 8'h01, 8'h00);
    step("cmp_gt", 8'hE6, 8'hAE, 4'hE, 8'h01, 8'h00);
    step("add_max", 8'hFF, 8'hFF, 4'h0, 8'hFE, 8'h01);
    step("mul_max", 8'hFF, 8'hFF, 4'h2, 8'h01, 8'hFE);
    step("sub_eq", 8'h33, 8'h33, 4'h1, 8'h00, 8'h00);

    // Back-to-back sweep of every opcode, one per cycle
    for (int op = 0; op < 16; op++)
      step_model("sweep", 8'hC3, 8'h1D, op[3:0]);

    // Random back-to-back operations against the model
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      logic [3:0] rop;
      ra = 8'($urandom);
      rb = (i % 17 == 0) ? 8'h00 : 8'($urandom);
      rop = 4'($urandom);
      step_model("rand", ra, rb, rop);
    end

    // Reset mid-stream discards the in-flight result
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; opcode = 4'h2;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.result", result, 8'h00);
    check("rst_mid.carry", carry, 8'h00);
    @(posedge clk); #1;
    check("rst_mid_hold.result", result, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    step("post_rst", 8'h10, 8'h20, 4'h1, 8'hF0, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
